// File: rtl/pe_mac_param.sv
// Output-stationary systolic PE: forwards data east / weight south, multiply-accumulates
// locally with optional saturation and a sticky overflow flag, and offers a shift-chain drain.
module pe_mac_param #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned WEIGHT_W = 8,
  parameter int unsigned ACC_W    = 20,
  parameter int unsigned SATURATE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic                in_first,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [WEIGHT_W-1:0] in_weight,
  output logic                out_valid,
  output logic                out_first,
  output logic [DATA_W-1:0]   out_data,
  output logic [WEIGHT_W-1:0] out_weight,
  output logic [ACC_W-1:0]    acc,
  output logic                ovf,
  input  logic                drain_load,
  input  logic                drain_shift,
  input  logic [ACC_W-1:0]    drain_in,
  input  logic                drain_vin,
  output logic [ACC_W-1:0]    drain_out,
  output logic                drain_vout
);

  localparam int unsigned PROD_W = DATA_W + WEIGHT_W;
  localparam int unsigned SUM_W  = ACC_W + 1;

  // The first product of an accumulation must always fit the accumulator.
  if (ACC_W < PROD_W) begin : g_acc_w_check
    $error("pe_mac_param: ACC_W must be >= DATA_W + WEIGHT_W");
  end

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                valid_q,   valid_d;
  logic                first_q,   first_d;
  logic [DATA_W-1:0]   data_q,    data_d;
  logic [WEIGHT_W-1:0] weight_q,  weight_d;
  logic [ACC_W-1:0]    acc_q,     acc_d;
  logic                ovf_q,     ovf_d;
  logic [ACC_W-1:0]    drain_q,   drain_d;
  logic                drain_v_q, drain_v_d;

  logic signed [PROD_W-1:0] prod_c;
  logic        [SUM_W-1:0]  prod_ext_c;
  logic        [SUM_W-1:0]  base_ext_c;
  logic        [SUM_W-1:0]  sum_c;
  logic                     sum_oor_c;
  logic        [ACC_W-1:0]  result_c;

  // Full-precision product and ACC_W+1 bit sum; out of range when the top two bits differ.
  always_comb begin
    prod_c     = $signed(in_data) * $signed(in_weight);
    prod_ext_c = {{(SUM_W-PROD_W){prod_c[PROD_W-1]}}, prod_c};
    base_ext_c = in_first ? '0 : {acc_q[ACC_W-1], acc_q};
    sum_c      = base_ext_c + prod_ext_c;
    sum_oor_c  = sum_c[ACC_W] ^ sum_c[ACC_W-1];
    result_c   = sum_c[ACC_W-1:0];
    if (sum_oor_c && (SATURATE != 0)) begin
      result_c = sum_c[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    first_d   = first_q;
    data_d    = data_q;
    weight_d  = weight_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    drain_d   = drain_q;
    drain_v_d = drain_v_q;
    if (en) begin
      valid_d  = in_valid;
      first_d  = in_first;
      data_d   = in_data;
      weight_d = in_weight;
      if (in_valid) begin
        acc_d = result_c;
        if (in_first) begin
          ovf_d = 1'b0;
        end else if (sum_oor_c) begin
          ovf_d = 1'b1;
        end
      end
      // Load samples the pre-edge accumulator, enabling a zero-bubble tile switch.
      if (drain_load) begin
        drain_d   = acc_q;
        drain_v_d = 1'b1;
      end else if (drain_shift) begin
        drain_d   = drain_in;
        drain_v_d = drain_vin;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      data_q    <= '0;
      weight_q  <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      drain_q   <= '0;
      drain_v_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      first_q   <= first_d;
      data_q    <= data_d;
      weight_q  <= weight_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      drain_q   <= drain_d;
      drain_v_q <= drain_v_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_first  = first_q;
  assign out_data   = data_q;
  assign out_weight = weight_q;
  assign acc        = acc_q;
  assign ovf        = ovf_q;
  assign drain_out  = drain_q;
  assign drain_vout = drain_v_q;

endmodule

// File: tb/tb_pe_mac_param.sv
// Scoreboard bench for pe_mac_param: a 3-PE saturating drain chain plus a wrapping PE
// that shares PE0's operand stream.
module tb_pe_mac_param;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic in_valid, in_first;
  logic drain_load, drain_shift;

  logic signed [11:0] d0, d1, d2;
  logic signed [7:0]  w0, w1, w2;

  logic               ov0, ov1, ov2, ovw;
  logic               of0, of1, of2, ofw;
  logic signed [11:0] od0, od1, od2, odw;
  logic signed [7:0]  ow0, ow1, ow2, oww;
  logic signed [19:0] acc0, acc1, acc2, accw;
  logic               ovf0, ovf1, ovf2, ovfw;
  logic signed [19:0] dr0, dr1, dr2, drw;
  logic               dv0, dv1, dv2, dvw;

  int tests = 0;
  int fails = 0;
  logic en_s;

  typedef struct {
    int acc; int ovf; int wacc; int wovf; int data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pe_mac_param #(.SATURATE(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_first(in_first),
    .in_data(d0), .in_weight(w0), .out_valid(ov0), .out_first(of0),
    .out_data(od0), .out_weight(ow0), .acc(acc0), .ovf(ovf0),
    .drain_load(drain_load), .drain_shift(drain_shift), .drain_in(20'd0),
    .drain_vin(1'b0), .drain_out(dr0), .drain_vout(dv0));

  pe_mac_param #(.SATURATE(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_first(in_first),
    .in_data(d1), .in_weight(w1), .out_valid(ov1), .out_first(of1),
    .out_data(od1), .out_weight(ow1), .acc(acc1), .ovf(ovf1),
    .drain_load(drain_load), .drain_shift(drain_shift), .drain_in(dr0),
    .drain_vin(dv0), .drain_out(dr1), .drain_vout(dv1));

  pe_mac_param #(.SATURATE(1)) u2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_first(in_first),
    .in_data(d2), .in_weight(w2), .out_valid(ov2), .out_first(of2),
    .out_data(od2), .out_weight(ow2), .acc(acc2), .ovf(ovf2),
    .drain_load(drain_load), .drain_shift(drain_shift), .drain_in(dr1),
    .drain_vin(dv1), .drain_out(dr2), .drain_vout(dv2));

  pe_mac_param #(.SATURATE(0)) uw (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_first(in_first),
    .in_data(d0), .in_weight(w0), .out_valid(ovw), .out_first(ofw),
    .out_data(odw), .out_weight(oww), .acc(accw), .ovf(ovfw),
    .drain_load(drain_load), .drain_shift(drain_shift), .drain_in(20'd0),
    .drain_vin(1'b0), .drain_out(drw), .drain_vout(dvw));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Tracks whether the last edge was enabled, so held outputs are not re-scored.
  always @(posedge clk or posedge rst) begin
    if (rst) en_s <= 1'b0;
    else     en_s <= en;
  end

  // Monitor: every enabled valid output of PE0 retires one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && en_s && ov0) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("acc",      int'(acc0), e.acc);
          chk("ovf",      int'(ovf0), e.ovf);
          chk("wrap_acc", int'(accw), e.wacc);
          chk("wrap_ovf", int'(ovfw), e.wovf);
          chk("out_data", int'(od0),  e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic first, input int d, input int w,
                       input int eacc, input int eovf, input int ewacc, input int ewovf);
    exp_t e;
    in_valid = 1'b1;
    in_first = first;
    d0 = 12'(d);
    w0 = 8'(w);
    e.acc = eacc; e.ovf = eovf; e.wacc = ewacc; e.wovf = ewovf; e.data = d;
    sb.push_back(e);
    step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_first = 1'b0;
    drain_load = 1'b0; drain_shift = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; w0 = '0; w1 = '0; w2 = '0;
    #12;
    chk("rst_acc", int'(acc0), 0);
    chk("rst_out_valid", int'(ov0), 0);
    chk("rst_drain_vout", int'(dv0), 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Accumulate to 12, capture into drain, then async reset between edges.
    issue(1'b1, 3, 4, 12, 0, 12, 0);
    in_valid = 1'b0; drain_load = 1'b1;
    step();
    drain_load = 1'b0;
    chk("drain_pre_rst", int'(dr0), 12);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_acc", int'(acc0), 0);
    chk("async_rst_out_data", int'(od0), 0);
    chk("async_rst_drain", int'(dr0), 0);
    chk("async_rst_dvout", int'(dv0), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    issue(1'b1, 3, 4, 12, 0, 12, 0);

    // Accumulate and forward.
    issue(1'b1, 3, 4, 12, 0, 12, 0);
    issue(1'b0, -5, 2, 2, 0, 2, 0);
    issue(1'b0, 7, -1, -5, 0, -5, 0);

    // Saturation vs wrap, then restart clears ovf.
    issue(1'b1, 2047, 127, 259969, 0, 259969, 0);
    issue(1'b0, 2047, 127, 519938, 0, 519938, 0);
    issue(1'b0, 2047, 127, 524287, 1, -268669, 1);
    issue(1'b0, 0, 0, 524287, 1, -268669, 1);
    issue(1'b1, 1, 1, 1, 0, 1, 0);

    // en=0 freezes everything.
    issue(1'b1, 3, 4, 12, 0, 12, 0);
    en = 1'b0; in_valid = 1'b1; in_first = 1'b1; d0 = 12'sd100; w0 = 8'sd5;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_acc", int'(acc0), 12);
      chk("hold_out_data", int'(od0), 3);
      chk("hold_out_valid", int'(ov0), 1);
    end
    en = 1'b1; in_valid = 1'b0; in_first = 1'b0; d0 = 12'sd9;
    step();
    chk("nv_acc", int'(acc0), 12);
    chk("nv_out_data", int'(od0), 9);
    chk("nv_out_valid", int'(ov0), 0);
    issue(1'b0, -5, 2, 2, 0, 2, 0);

    // Drain chain: build 10/20/30, tile switch with drain_load, then shift out.
    d1 = 12'sd4; w1 = 8'sd5; d2 = 12'sd6; w2 = 8'sd5;
    issue(1'b1, 2, 5, 10, 0, 10, 0);
    chk("pe1_acc", int'(acc1), 20);
    chk("pe2_acc", int'(acc2), 30);
    drain_load = 1'b1;
    d1 = 12'sd2; w1 = 8'sd2; d2 = 12'sd2; w2 = 8'sd2;
    issue(1'b1, 2, 2, 4, 0, 4, 0);
    drain_load = 1'b0; in_valid = 1'b0; in_first = 1'b0;
    chk("drain0", int'(dr0), 10);
    chk("drain1", int'(dr1), 20);
    chk("drain2", int'(dr2), 30);
    chk("switch_acc1", int'(acc1), 4);
    chk("switch_acc2", int'(acc2), 4);
    chk("drain2_v0", int'(dv2), 1);
    drain_shift = 1'b1;
    step();
    chk("shift1_d", int'(dr2), 20);
    chk("shift1_v", int'(dv2), 1);
    step();
    chk("shift2_d", int'(dr2), 10);
    chk("shift2_v", int'(dv2), 1);
    step();
    chk("shift3_d", int'(dr2), 0);
    chk("shift3_v", int'(dv2), 0);
    chk("drain_keeps_acc", int'(acc2), 4);
    drain_shift = 1'b0;

    repeat (2) step();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
